ddrphy_rst_seq: RTL and testbench

DDRPHY_RST_SEQ -- requirements
Module: ddrphy_rst_seq

---
 rtl/ddrphy_rst_seq.sv | 145 ++++++++++++++
 tb/tb_ddrphy_rst_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddrphy_rst_seq.sv
// rtl/ddrphy_rst_seq.sv - DDR PHY reset / training-reset request sequencer
// Drives in_rst after PLL lock, issues acked training-reset requests with retry and update service.
module ddrphy_rst_seq #(
  parameter int IN_RST_CYCLES = 16,
  parameter int ACK_TIMEOUT   = 64,
  parameter int MAX_RETRY     = 3,
  parameter int REQ_GAP       = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic pll_lock,
  input  logic update_req,
  input  logic ddrphy_rst_ack,
  output logic ddrphy_in_rst,
  output logic ddrphy_rst_req,
  output logic phy_ready,
  output logic update_ack,
  output logic timeout_err
);

  typedef enum logic [2:0] {S_RESET, S_HOLD, S_REQ, S_GAP, S_READY, S_ERR} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(IN_RST_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(REQ_GAP - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;
  logic       lock_s1_q, lock_s1_d, lock_s_q, lock_s_d;
  logic       succ_q, succ_d;
  logic       pend_q, pend_d;
  logic       req_upd_q, req_upd_d;
  logic       in_rst_q, in_rst_d;
  logic       rst_req_q, rst_req_d;
  logic       ready_q, ready_d;
  logic       uack_q, uack_d;
  logic       err_q, err_d;

  always_comb begin
    lock_s1_d = pll_lock;
    lock_s_d  = lock_s1_q;
    state_d   = state_q;
    cnt_d     = '0;
    retry_d   = retry_q;
    succ_d    = succ_q;
    pend_d    = pend_q | (update_req && (state_q != S_ERR));
    req_upd_d = req_upd_q;
    uack_d    = 1'b0;

    case (state_q)
      S_RESET: if (lock_s_q) state_d = S_HOLD;
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_REQ;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      S_REQ: begin
        // Ack takes priority over an expiring timeout in the same cycle
        if (ddrphy_rst_ack) begin
          state_d   = S_GAP;
          succ_d    = 1'b1;
          retry_d   = '0;
          uack_d    = req_upd_q;
          req_upd_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 3'd1;
          succ_d  = 1'b0;
          state_d = (retry_d < RETRY_MAX) ? S_GAP : S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = succ_q ? S_READY : S_REQ;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      S_READY: begin
        if (pend_q || update_req) begin
          state_d   = S_REQ;
          pend_d    = 1'b0;
          req_upd_d = 1'b1;
          succ_d    = 1'b0;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RESET;
    endcase

    // Lock loss aborts any in-flight work but remembers a requested update
    if (!lock_s_q && (state_q != S_RESET) && (state_q != S_ERR)) begin
      state_d   = S_RESET;
      cnt_d     = '0;
      retry_d   = '0;
      succ_d    = 1'b0;
      req_upd_d = 1'b0;
      uack_d    = 1'b0;
      pend_d    = pend_q | update_req;
    end

    in_rst_d  = (state_d == S_RESET) || (state_d == S_HOLD) || (state_d == S_ERR);
    rst_req_d = (state_d == S_REQ);
    ready_d   = (state_d == S_READY);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
      succ_q    <= 1'b0;
      pend_q    <= 1'b0;
      req_upd_q <= 1'b0;
      in_rst_q  <= 1'b1;
      rst_req_q <= 1'b0;
      ready_q   <= 1'b0;
      uack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lock_s1_q <= lock_s1_d;
      lock_s_q  <= lock_s_d;
      succ_q    <= succ_d;
      pend_q    <= pend_d;
      req_upd_q <= req_upd_d;
      in_rst_q  <= in_rst_d;
      rst_req_q <= rst_req_d;
      ready_q   <= ready_d;
      uack_q    <= uack_d;
      err_q     <= err_d;
    end
  end

  assign ddrphy_in_rst  = in_rst_q;
  assign ddrphy_rst_req = rst_req_q;
  assign phy_ready      = ready_q;
  assign update_ack     = uack_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_ddrphy_rst_seq.sv
// tb/tb_ddrphy_rst_seq.sv - self-checking bench for ddrphy_rst_seq
// Request pulses are checked against a queue of expected {width, update_ack} records.
`timescale 1ns/1ps
module tb_ddrphy_rst_seq;

  localparam int IN_RST = 16;
  localparam int TO     = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pll_lock = 1'b0;
  logic update_req = 1'b0;
  logic ddrphy_rst_ack;
  logic ddrphy_in_rst, ddrphy_rst_req, phy_ready, update_ack, timeout_err;

  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  assign ddrphy_rst_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  ddrphy_rst_seq dut (
    .clk(clk), .rstn(rstn), .pll_lock(pll_lock), .update_req(update_req),
    .ddrphy_rst_ack(ddrphy_rst_ack), .ddrphy_in_rst(ddrphy_in_rst),
    .ddrphy_rst_req(ddrphy_rst_req), .phy_ready(phy_ready),
    .update_ack(update_ack), .timeout_err(timeout_err)
  );

  typedef struct { int width; bit uack; } exp_t;
  typedef struct { int ack_delay; int exp_width; bit exp_uack; } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_dly = 6;
  int   req_age = 0;
  int   run = 0;
  int   low_run = 0;
  int   uack_total = 0;
  bit   gap_chk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream responder: ack on REQ cycle index ack_dly (-1 = never)
  always @(negedge clk) begin
    if (ddrphy_rst_req) req_age++;
    else                req_age = 0;
    resp_ack = (ack_dly >= 0) && ddrphy_rst_req && (req_age == ack_dly + 1);
  end

  // Scoreboard: each completed request pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      run = 0;
    end else if (ddrphy_rst_req) begin
      if (run == 0 && gap_chk) chk("req_gap", low_run, 4);
      run++;
      low_run = 0;
    end else begin
      low_run++;
      if (run > 0) begin
        if (exp_q.size() == 0) chk("unexpected_req_pulse", run, 0);
        else begin
          e = exp_q.pop_front();
          chk("req_width", run, e.width);
          chk("uack_on_ack", int'(update_ack), int'(e.uack));
        end
        run = 0;
      end
    end
    if (update_ack) uack_total++;
  end

  task automatic pulse_update();
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!phy_ready && n < budget) begin @(negedge clk); n++; end
    chk(name, int'(phy_ready), 1);
  endtask

  task automatic lock_to_inrst_low(input string name);
    int n = 0;
    pll_lock = 1'b1;
    while (ddrphy_in_rst && n < 100) begin @(negedge clk); n++; end
    chk(name, n, 2 + 1 + IN_RST);
    chk({name, "_req_rise"}, int'(ddrphy_rst_req), 1);
  endtask

  initial begin
    vec_t vecs[6];
    int   n, u0;
    vecs[0] = '{6, 7, 1'b1};
    vecs[1] = '{0, 1, 1'b1};
    vecs[2] = '{1, 2, 1'b1};
    vecs[3] = '{20, 21, 1'b1};
    vecs[4] = '{62, 63, 1'b1};
    vecs[5] = '{63, 64, 1'b1};

    // Power-up
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({ddrphy_in_rst, ddrphy_rst_req, phy_ready, update_ack, timeout_err}), 5'b10000);
    rstn = 1'b1;
    exp_q.push_back('{7, 1'b0});
    repeat (10) @(negedge clk);
    chk("in_rst_before_lock", int'(ddrphy_in_rst), 1);
    lock_to_inrst_low("powerup_in_rst_cycles");
    n = 0;
    while (ddrphy_rst_req && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!phy_ready && !ddrphy_rst_req && n < 100) begin @(negedge clk); n++; end
    chk("powerup_gap_cycles", n, 4);
    chk("powerup_ready", int'(phy_ready), 1);
    chk("powerup_no_uack", uack_total, 0);

    // Update requests, one per table vector
    for (int i = 0; i < 6; i++) begin
      ack_dly = vecs[i].ack_delay;
      u0 = uack_total;
      exp_q.push_back('{vecs[i].exp_width, vecs[i].exp_uack});
      pulse_update();
      chk("ready_drop", int'(phy_ready), 0);
      chk("req_rise", int'(ddrphy_rst_req), 1);
      wait_ready("vec_ready", 300);
      chk("vec_uack_count", uack_total - u0, 1);
    end

    // Stray ack outside REQ is ignored
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_ack_ready", int'(phy_ready), 1);

    // Second update during REQ yields exactly one extra request
    ack_dly = 6;
    u0 = uack_total;
    exp_q.push_back('{7, 1'b1});
    exp_q.push_back('{7, 1'b1});
    pulse_update();
    repeat (3) @(negedge clk);
    pulse_update();
    repeat (30) @(negedge clk);
    wait_ready("double_ready", 300);
    repeat (40) @(negedge clk);
    chk("double_uack_count", uack_total - u0, 2);
    chk("double_queue_empty", exp_q.size(), 0);

    // Lock loss during REQ, then relock repeats the full sequence
    ack_dly = -1;
    exp_q.push_back('{5, 1'b0});
    pulse_update();
    repeat (2) @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    chk("lockloss_outs", int'({ddrphy_rst_req, ddrphy_in_rst}), 2'b01);
    ack_dly = 6;
    exp_q.push_back('{7, 1'b0});
    u0 = uack_total;
    lock_to_inrst_low("relock_in_rst_cycles");
    wait_ready("relock_ready", 300);
    chk("relock_no_uack", uack_total - u0, 0);

    // Timeout and retry exhaustion
    ack_dly = -1;
    repeat (3) exp_q.push_back('{TO, 1'b0});
    pulse_update();
    @(negedge clk);
    gap_chk = 1'b1;
    n = 0;
    while (!timeout_err && n < 400) begin @(negedge clk); n++; end
    chk("timeout_err_set", int'(timeout_err), 1);
    repeat (20) @(negedge clk);
    gap_chk = 1'b0;
    chk("err_outs", int'({ddrphy_in_rst, ddrphy_rst_req, phy_ready}), 3'b100);
    chk("err_queue_empty", exp_q.size(), 0);

    // Async reset out of ERR, checked away from any clock edge
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_outs", int'({ddrphy_in_rst, ddrphy_rst_req, phy_ready, update_ack, timeout_err}), 5'b10000);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
